fp_round_pipe: RTL

//  Parametrised, pipelined IEEE-754 rounding/packing stage for the F-extension datapath. Successor to the

---
 rtl/fp_pkg.sv | 49 ++++
 rtl/fp_round_decide.sv | 31 +++
 rtl/fp_round_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, fflags layout and
// width-parametrised constant encodings (returned in 64 bits, caller slices).
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Result category chosen before the mantissa add.
  typedef enum logic [2:0] {
    SEL_ROUND,
    SEL_NAN,
    SEL_INF,
    SEL_ZERO,
    SEL_TINY,
    SEL_OVF
  } sel_e;

  function automatic logic [63:0] pos_inf(input int ew, input int mw);
    return ((64'd1 << ew) - 64'd1) << mw;
  endfunction

  function automatic logic [63:0] canon_nan(input int ew, input int mw);
    return pos_inf(ew, mw) | (64'd1 << (mw - 1));
  endfunction

  function automatic logic [63:0] max_finite(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Round-increment decision from rounding mode, sign and guard/round/sticky.
module fp_round_decide
  import fp_pkg::*;
(
  input  logic [2:0] i_rm,
  input  logic       i_sign,
  input  logic [2:0] i_grs,
  input  logic       i_lsb,
  output logic       o_inc,
  output logic       o_nx
);

  logic w_g, w_rs;

  assign w_g  = i_grs[2];
  assign w_rs = i_grs[1] | i_grs[0];
  assign o_nx = |i_grs;

  always_comb begin
    o_inc = 1'b0;
    case (rm_e'(i_rm))
      RM_RNE:  o_inc = w_g & (w_rs | i_lsb);
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & o_nx;
      RM_RUP:  o_inc = !i_sign & o_nx;
      RM_RMM:  o_inc = w_g;
      default: o_inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_round_pipe.sv
// Pipelined IEEE-754 round/pack stage with valid/ready handshake and flush.
// STAGES=2 splits decide/special-select from add/overflow/pack.
module fp_round_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_flush,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [MAN_W-1:0]       in_man,
  input  logic [2:0]             in_grs,
  input  logic [2:0]             in_rm,
  input  logic                   in_nan,
  input  logic                   in_nv,
  input  logic                   in_inf,
  input  logic                   in_tiny,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [4:0]             out_fflags
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [63:0]    NAN64  = canon_nan(EXP_W, MAN_W);
  localparam logic [63:0]    INF64  = pos_inf(EXP_W, MAN_W);
  localparam logic [63:0]    MAXF64 = max_finite(EXP_W, MAN_W);
  localparam logic [W-2:0]   NAN_EM  = NAN64[W-2:0];
  localparam logic [W-2:0]   INF_EM  = INF64[W-2:0];
  localparam logic [W-2:0]   MAXF_EM = MAXF64[W-2:0];
  localparam logic [EXP_W:0] MAXE    = {1'b0, {EXP_W{1'b1}}};

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [MAN_W-1:0] man;
    logic             inc;
    logic             nx;
    logic             nv;
    rm_e              rm;
    sel_e             sel;
  } mid_t;

  logic              w_inc, w_nx, w_acc, w_to_inf, w_ovf;
  logic [STAGES:1]   r_vld_pipe, w_adv;
  logic [STAGES-1:0] w_chain;
  mid_t              w_dec, w_mid;
  logic [MAN_W:0]    w_sum;
  logic [EXP_W:0]    w_exp_r;
  logic [W-1:0]      w_res, r_res;
  logic [4:0]        w_flags;
  fflags_t           r_flags;

  fp_round_decide u_decide (
    .i_rm   (in_rm),
    .i_sign (in_sign),
    .i_grs  (in_grs),
    .i_lsb  (in_man[0]),
    .o_inc  (w_inc),
    .o_nx   (w_nx)
  );

  // Handshake: a stage loads when empty or when the stage after it moves.
  assign w_adv[STAGES] = !r_vld_pipe[STAGES] || out_ready;
  for (genvar k = 1; k < STAGES; k++) begin : g_adv
    assign w_adv[k] = !r_vld_pipe[k] || w_adv[k+1];
  end
  assign in_ready  = w_adv[1] && !in_flush;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_vld_pipe[STAGES];

  always_comb begin
    w_dec      = '0;
    w_dec.sign = in_sign;
    w_dec.exp  = in_exp;
    w_dec.man  = in_man;
    w_dec.inc  = w_inc;
    w_dec.nx   = w_nx;
    w_dec.rm   = rm_e'(in_rm);
    w_dec.sel  = SEL_ROUND;
    if (in_rm > 3'b100) begin
      w_dec.sel = SEL_NAN;
      w_dec.nv  = 1'b1;
    end else if (in_nan) begin
      w_dec.sel = SEL_NAN;
      w_dec.nv  = in_nv;
    end else if (in_inf)                                     w_dec.sel = SEL_INF;
    else if (in_exp == '0 && in_man == '0 && in_grs == '0)   w_dec.sel = SEL_ZERO;
    else if (in_tiny)                                        w_dec.sel = SEL_TINY;
    else if (in_exp >= MAXE)                                 w_dec.sel = SEL_OVF;
  end

  if (STAGES == 2) begin : g_two
    mid_t r_s1;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_s1 <= '0;
      else if (w_acc) r_s1 <= w_dec;
    end
    assign w_mid   = r_s1;
    assign w_chain = {r_vld_pipe[1], w_acc};
  end else begin : g_one
    assign w_mid   = w_dec;
    assign w_chain = w_acc;
  end

  // Carry out of the mantissa leaves man'=0 and bumps the exponent.
  always_comb begin
    w_sum    = {1'b0, w_mid.man} + {{MAN_W{1'b0}}, w_mid.inc};
    w_exp_r  = w_mid.exp + {{EXP_W{1'b0}}, w_sum[MAN_W]};
    w_ovf    = (w_mid.sel == SEL_OVF) || (w_mid.sel == SEL_ROUND && w_exp_r == MAXE);
    w_to_inf = 1'b1;
    case (w_mid.rm)
      RM_RTZ:  w_to_inf = 1'b0;
      RM_RDN:  w_to_inf = w_mid.sign;
      RM_RUP:  w_to_inf = !w_mid.sign;
      default: w_to_inf = 1'b1;
    endcase
    w_res   = '0;
    w_flags = '0;
    case (w_mid.sel)
      SEL_NAN: begin
        w_res            = {1'b0, NAN_EM};
        w_flags[FLAG_NV] = w_mid.nv;
      end
      SEL_INF:  w_res = {w_mid.sign, INF_EM};
      SEL_ZERO: w_res = {w_mid.sign, {(W-1){1'b0}}};
      SEL_TINY: begin
        w_res            = {w_mid.sign, {(W-1){1'b0}}};
        w_flags[FLAG_UF] = 1'b1;
        w_flags[FLAG_NX] = 1'b1;
      end
      default: begin
        if (w_ovf) begin
          w_res            = {w_mid.sign, w_to_inf ? INF_EM : MAXF_EM};
          w_flags[FLAG_OF] = 1'b1;
          w_flags[FLAG_NX] = 1'b1;
        end else begin
          w_res            = {w_mid.sign, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
          w_flags[FLAG_NX] = w_mid.nx;
        end
      end
    endcase
  end

  // Flush wins over any advance in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_vld_pipe <= '0;
    else if (in_flush) r_vld_pipe <= '0;
    else begin
      for (int k = 1; k <= STAGES; k++)
        if (w_adv[k]) r_vld_pipe[k] <= w_chain[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_adv[STAGES] && w_chain[STAGES-1]) begin
      r_res   <= w_res;
      r_flags <= fflags_t'(w_flags);
    end
  end

  assign out_result = r_res;
  assign out_fflags = r_flags;

endmodule
